// File: rtl/pc_stack_seq.sv
// Program-counter sequencer with a small hardware return-address stack.
// It keeps the current instruction address and picks the next one:
// sequential pc+1, a jump target, a subroutine call, or a return.
// The pc output drives the instruction-memory address bus directly.
module pc_stack_seq #(
  parameter int AW    = 10,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          s,
  input  logic [AW-1:0] jump_addr,
  input  logic          call,
  input  logic          ret,
  output logic [AW-1:0] pc,
  output logic [4:0]    depth,
  output logic          stack_full,
  output logic          stack_empty,
  output logic          err
);

  // Index width for the stack array; at least one bit even when DEPTH is 1.
  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  DEPTH_W = 5'(DEPTH);

  logic [AW-1:0] pc_q, pc_d;
  logic [4:0]    depth_q, depth_d;
  logic          err_q, err_d;

  // Return-address storage; contents are don't-care after reset and are
  // only ever read below the current depth.
  logic [AW-1:0] stack_q [DEPTH];

  logic          push_en;
  logic [IW-1:0] push_idx;
  logic [IW-1:0] pop_idx;
  logic [4:0]    top_pos;
  logic [AW-1:0] pc_plus_one;
  logic          full_w;
  logic          empty_w;

  assign pc_plus_one = pc_q + AW'(1);
  assign full_w      = (depth_q == DEPTH_W);
  assign empty_w     = (depth_q == 5'd0);
  assign top_pos     = depth_q - 5'd1;
  assign push_idx    = depth_q[IW-1:0];
  assign pop_idx     = top_pos[IW-1:0];

  // Next-state selection: stall beats ret, ret beats call, call beats jump.
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    err_d   = err_q;
    push_en = 1'b0;
    if (!stall) begin
      if (ret) begin
        if (!empty_w) begin
          pc_d    = stack_q[pop_idx];
          depth_d = depth_q - 5'd1;
        end else begin
          pc_d  = pc_plus_one;
          err_d = 1'b1;
        end
      end else if (call) begin
        pc_d = jump_addr;
        if (!full_w) begin
          push_en = 1'b1;
          depth_d = depth_q + 5'd1;
        end else begin
          err_d = 1'b1;
        end
      end else if (s) begin
        pc_d = jump_addr;
      end else begin
        pc_d = pc_plus_one;
      end
    end
  end

  // Architectural state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Stack write port; a push during reset is suppressed so reset wins.
  always_ff @(posedge clk) begin
    if (!reset && push_en) begin
      stack_q[push_idx] <= pc_plus_one;
    end
  end

  assign pc          = pc_q;
  assign depth       = depth_q;
  assign err         = err_q;
  assign stack_full  = full_w;
  assign stack_empty = empty_w;

endmodule

// File: tb/tb_pc_stack_seq.sv
// Directed self-checking bench for pc_stack_seq (AW=10, DEPTH=4).
module tb_pc_stack_seq;

  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          stall;
  logic          s;
  logic [AW-1:0] jump_addr;
  logic          call;
  logic          ret;
  logic [AW-1:0] pc;
  logic [4:0]    depth;
  logic          stack_full;
  logic          stack_empty;
  logic          err;

  int checks;
  int errors;

  pc_stack_seq #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .s           (s),
    .jump_addr   (jump_addr),
    .call        (call),
    .ret         (ret),
    .pc          (pc),
    .depth       (depth),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .err         (err)
  );

  // 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let an edge take them, sample 1 unit later.
  task automatic applyStimulus(input logic rst, input logic stl, input logic sel,
                               input logic cl, input logic rt,
                               input logic [AW-1:0] ja);
    reset     = rst;
    stall     = stl;
    s         = sel;
    call      = cl;
    ret       = rt;
    jump_addr = ja;
    @(posedge clk);
    #1;
  endtask

  // Compare every observable output against hand-computed expectations.
  task automatic checkOutput(input string tag, input logic [AW-1:0] expPc,
                             input logic [4:0] expDepth, input logic expErr);
    logic expFull;
    logic expEmpty;
    expFull  = (expDepth == 5'd4);
    expEmpty = (expDepth == 5'd0);
    checks++;
    assert (pc === expPc) else begin
      errors++;
      $error("[TB] FAIL %s pc: got %h expected %h", tag, pc, expPc);
    end
    checks++;
    assert (depth === expDepth) else begin
      errors++;
      $error("[TB] FAIL %s depth: got %0d expected %0d", tag, depth, expDepth);
    end
    checks++;
    assert (err === expErr) else begin
      errors++;
      $error("[TB] FAIL %s err: got %b expected %b", tag, err, expErr);
    end
    checks++;
    assert (stack_full === expFull) else begin
      errors++;
      $error("[TB] FAIL %s stack_full: got %b expected %b", tag, stack_full, expFull);
    end
    checks++;
    assert (stack_empty === expEmpty) else begin
      errors++;
      $error("[TB] FAIL %s stack_empty: got %b expected %b", tag, stack_empty, expEmpty);
    end
  endtask

  // Linear directed sequence.
  initial begin
    checks = 0;
    errors = 0;

    // Reset held for two edges, then free-run sequencing.
    applyStimulus(1, 0, 0, 0, 0, 10'h000);
    applyStimulus(1, 0, 0, 0, 0, 10'h000);
    checkOutput("reset", 10'h000, 5'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 10'h000);
    checkOutput("seq1", 10'h001, 5'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 10'h000);
    checkOutput("seq2", 10'h002, 5'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 10'h000);
    checkOutput("seq3", 10'h003, 5'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 10'h000);
    checkOutput("seq4", 10'h004, 5'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 10'h000);
    checkOutput("seq5", 10'h005, 5'd0, 1'b0);

    // Jump near the top of the address space and wrap.
    applyStimulus(0, 0, 1, 0, 0, 10'h3FE);
    checkOutput("jump3FE", 10'h3FE, 5'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 10'h3FE);
    checkOutput("inc3FF", 10'h3FF, 5'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 10'h3FE);
    checkOutput("wrap000", 10'h000, 5'd0, 1'b0);

    // Stall ignores s/call/ret.
    applyStimulus(0, 1, 1, 0, 0, 10'h155);
    checkOutput("stall1", 10'h000, 5'd0, 1'b0);
    applyStimulus(0, 1, 0, 1, 0, 10'h155);
    checkOutput("stall2", 10'h000, 5'd0, 1'b0);
    applyStimulus(0, 1, 0, 0, 1, 10'h155);
    checkOutput("stall3", 10'h000, 5'd0, 1'b0);

    // Nested call/return from pc=5.
    applyStimulus(0, 0, 1, 0, 0, 10'h005);
    checkOutput("to5", 10'h005, 5'd0, 1'b0);
    applyStimulus(0, 0, 1, 1, 0, 10'h100);
    checkOutput("call100", 10'h100, 5'd1, 1'b0);
    applyStimulus(0, 0, 0, 1, 0, 10'h200);
    checkOutput("call200", 10'h200, 5'd2, 1'b0);
    applyStimulus(0, 0, 1, 0, 1, 10'h3C0);
    checkOutput("ret101", 10'h101, 5'd1, 1'b0);
    applyStimulus(0, 0, 0, 0, 1, 10'h000);
    checkOutput("ret006", 10'h006, 5'd0, 1'b0);

    // Five calls from pc=6: fifth overflows, no push.
    applyStimulus(0, 0, 0, 1, 0, 10'h010);
    checkOutput("ovf_c1", 10'h010, 5'd1, 1'b0);
    applyStimulus(0, 0, 0, 1, 0, 10'h020);
    checkOutput("ovf_c2", 10'h020, 5'd2, 1'b0);
    applyStimulus(0, 0, 0, 1, 0, 10'h030);
    checkOutput("ovf_c3", 10'h030, 5'd3, 1'b0);
    applyStimulus(0, 0, 0, 1, 0, 10'h040);
    checkOutput("ovf_c4", 10'h040, 5'd4, 1'b0);
    applyStimulus(0, 0, 0, 1, 0, 10'h050);
    checkOutput("ovf_c5", 10'h050, 5'd4, 1'b1);
    applyStimulus(0, 0, 0, 0, 1, 10'h000);
    checkOutput("ovf_r1", 10'h031, 5'd3, 1'b1);
    applyStimulus(0, 0, 0, 0, 1, 10'h000);
    checkOutput("ovf_r2", 10'h021, 5'd2, 1'b1);
    applyStimulus(0, 0, 0, 0, 1, 10'h000);
    checkOutput("ovf_r3", 10'h011, 5'd1, 1'b1);
    applyStimulus(0, 0, 0, 0, 1, 10'h000);
    checkOutput("ovf_r4", 10'h007, 5'd0, 1'b1);

    // Clear err, then underflow at pc=0x20.
    applyStimulus(1, 0, 0, 0, 0, 10'h000);
    checkOutput("reset2", 10'h000, 5'd0, 1'b0);
    applyStimulus(0, 0, 1, 0, 0, 10'h020);
    checkOutput("to20", 10'h020, 5'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, 1, 10'h000);
    checkOutput("underflow", 10'h021, 5'd0, 1'b1);

    // call+ret together with one entry holding 0x50: ret wins.
    applyStimulus(0, 0, 1, 0, 0, 10'h04F);
    checkOutput("to4F", 10'h04F, 5'd0, 1'b1);
    applyStimulus(0, 0, 0, 1, 0, 10'h300);
    checkOutput("call300", 10'h300, 5'd1, 1'b1);
    applyStimulus(0, 0, 1, 1, 1, 10'h123);
    checkOutput("callret", 10'h050, 5'd0, 1'b1);
    applyStimulus(0, 1, 0, 0, 0, 10'h000);
    checkOutput("stallErr", 10'h050, 5'd0, 1'b1);

    // Build depth 2, confirm stall holds a ret, then reset mid-call.
    applyStimulus(0, 0, 0, 1, 0, 10'h010);
    checkOutput("rc_c1", 10'h010, 5'd1, 1'b1);
    applyStimulus(0, 0, 0, 1, 0, 10'h020);
    checkOutput("rc_c2", 10'h020, 5'd2, 1'b1);
    applyStimulus(0, 1, 0, 0, 1, 10'h000);
    checkOutput("stallRet", 10'h020, 5'd2, 1'b1);
    applyStimulus(1, 0, 0, 1, 0, 10'h3AA);
    checkOutput("resetCall", 10'h000, 5'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 10'h000);
    checkOutput("postReset", 10'h001, 5'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
